// File: rtl/matmul_pkg.sv
// matmul_pkg: shared FSM state type and width helpers for the matmul sequencer.
package matmul_pkg;

   typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

   function automatic int acc_width(input int n, input int dw);
      return 2 * dw + $clog2(n);
   endfunction

   function automatic int idx_width(input int n);
      return $clog2(n * n);
   endfunction

   function automatic int cnt_width(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/matmul_mac.sv
// matmul_mac: combinational multiply-accumulate step, (clear ? 0 : acc_in) + a*b.
// Define MATMUL_SIGNED_EN for two's-complement operands and results.
module matmul_mac #(
   parameter int DW = 8,
   parameter int ACC_W = 17
) (
   input  logic             clear,
   input  logic [ACC_W-1:0] acc_in,
   input  logic [DW-1:0]    a,
   input  logic [DW-1:0]    b,
   output logic [ACC_W-1:0] sum
);

   logic [2*DW-1:0] p;
   logic ea, eb, ep;

`ifdef MATMUL_SIGNED_EN
   assign ea = a[DW-1];
   assign eb = b[DW-1];
   assign ep = p[2*DW-1];
`else
   assign ea = 1'b0;
   assign eb = 1'b0;
   assign ep = 1'b0;
`endif

   // low 2*DW bits of the extended product are correct for either signedness
   assign p = {{DW{ea}}, a} * {{DW{eb}}, b};
   assign sum = (clear ? '0 : acc_in) + {{(ACC_W - 2 * DW){ep}}, p};

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: loads NxN A/B, runs N^3 MAC steps on one multiplier, streams C out.
// Define MATMUL_SIGNED_EN for signed arithmetic (handled in matmul_mac).
module matmul_sequencer
   import matmul_pkg::*;
#(
   parameter int N = 2,
   parameter int DW = 8,
   localparam int ACC_W = acc_width(N, DW)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_a,
   input  logic [DW-1:0]    in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             busy,
   output logic             done
);

   localparam int IW = idx_width(N);
   localparam int KW = cnt_width(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(N * N - 1);
   localparam logic [KW-1:0] LAST_K = KW'(N - 1);

   state_t state, nstate;
   logic [IW-1:0] cnt, a_idx, b_idx, c_idx;
   logic [KW-1:0] i, j, k;
   logic [ACC_W-1:0] acc, sum;
   logic [DW-1:0] a_buf [N*N];
   logic [DW-1:0] b_buf [N*N];
   logic [ACC_W-1:0] c_buf [N*N];
   logic primed, last_step, out_fire, last_out;

   assign a_idx = IW'(i) * IW'(N) + IW'(k);
   assign b_idx = IW'(k) * IW'(N) + IW'(j);
   assign c_idx = IW'(i) * IW'(N) + IW'(j);
   assign last_step = (i == LAST_K) && (j == LAST_K) && (k == LAST_K);
   assign last_out = cnt == LAST_IDX;
   assign out_fire = out_valid && out_ready;

   assign in_ready = state == LOAD;
   assign busy = state != LOAD;
   // one settle cycle in DRAIN before the first element is presented
   assign out_valid = (state == DRAIN) && primed;
   assign out_data = out_valid ? c_buf[cnt] : '0;

   matmul_mac #(.DW(DW), .ACC_W(ACC_W)) u_mac (
      .clear(k == '0),
      .acc_in(acc),
      .a(a_buf[a_idx]),
      .b(b_buf[b_idx]),
      .sum(sum)
   );

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= LOAD;
      else state <= nstate;

   always_comb begin
      nstate = state;
      case (state)
         LOAD:    nstate = (in_valid && last_out) ? COMPUTE : LOAD;
         COMPUTE: nstate = last_step ? DRAIN : COMPUTE;
         DRAIN:   nstate = (out_fire && last_out) ? LOAD : DRAIN;
         default: nstate = LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0;
         i <= '0;
         j <= '0;
         k <= '0;
         acc <= '0;
         primed <= 1'b0;
         done <= 1'b0;
         for (int e = 0; e < N * N; e++) begin
            a_buf[e] <= '0;
            b_buf[e] <= '0;
            c_buf[e] <= '0;
         end
      end else begin
         done <= (state == DRAIN) && out_fire && last_out;
         primed <= (state == DRAIN) && !(out_fire && last_out);
         if (state == LOAD && in_valid) begin
            a_buf[cnt] <= in_a;
            b_buf[cnt] <= in_b;
            cnt <= last_out ? '0 : cnt + 1'b1;
         end
         if (state == COMPUTE) begin
            acc <= sum;
            if (k == LAST_K) c_buf[c_idx] <= sum;
            k <= (k == LAST_K) ? '0 : k + 1'b1;
            if (k == LAST_K) j <= (j == LAST_K) ? '0 : j + 1'b1;
            if (k == LAST_K && j == LAST_K) i <= (i == LAST_K) ? '0 : i + 1'b1;
         end
         if (state == DRAIN && out_fire) cnt <= last_out ? '0 : cnt + 1'b1;
      end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: table-driven and randomized checks of the 2x2 matmul sequencer.
// Build with MATMUL_SIGNED_EN defined to exercise the signed configuration.
module tb_matmul_sequencer;

   typedef struct {
      logic [3:0][7:0]  a;
      logic [3:0][7:0]  b;
      logic [3:0][16:0] c;
      int               stall;
      bit               hold;
   } vec_t;

   logic clk = 1'b0;
   logic rst, in_valid, in_ready, out_valid, out_ready, busy, done;
   logic [7:0] in_a, in_b;
   logic [16:0] out_data;
   int checks = 0;
   int failures = 0;
   vec_t tbl [4];

   always #5 clk = ~clk;

   matmul_sequencer #(.N(2), .DW(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .busy(busy), .done(done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   function automatic int val(input logic [7:0] x);
`ifdef MATMUL_SIGNED_EN
      return int'($signed(x));
`else
      return int'(x);
`endif
   endfunction

   function automatic logic [3:0][16:0] model(input logic [3:0][7:0] a, input logic [3:0][7:0] b);
      logic [3:0][16:0] r;
      for (int ri = 0; ri < 2; ri++)
         for (int ci = 0; ci < 2; ci++) begin
            int s = 0;
            for (int ki = 0; ki < 2; ki++) s += val(a[ri*2+ki]) * val(b[ki*2+ci]);
            r[ri*2+ci] = 17'(s);
         end
      return r;
   endfunction

   task automatic load(input logic [3:0][7:0] a, input logic [3:0][7:0] b);
      for (int e = 0; e < 4; e++) begin
         in_valid = 1'b1;
         in_a = a[e];
         in_b = b[e];
         check("in_ready_load", in_ready, 1);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run(input vec_t v);
      int cyc = 0;
      load(v.a, v.b);
      in_valid = v.hold;
      while (!out_valid && cyc < 100) begin
         check("busy_compute", busy, 1);
         check("in_ready_compute", in_ready, 0);
         in_a = 8'($urandom);
         in_b = 8'($urandom);
         @(posedge clk);
         #1;
         cyc++;
      end
      check("latency", cyc, 9);
      for (int e = 0; e < 4; e++) begin
         out_ready = 1'b0;
         for (int s = 0; s < v.stall; s++) begin
            check("held_valid", out_valid, 1);
            check("held_data", out_data, v.c[e]);
            @(posedge clk);
            #1;
         end
         check("out_valid", out_valid, 1);
         check("out_data", out_data, v.c[e]);
         check("in_ready_drain", in_ready, 0);
         check("done_early", done, 0);
         out_ready = 1'b1;
         if (e == 3) in_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      out_ready = 1'b0;
      check("done_pulse", done, 1);
      check("in_ready_after", in_ready, 1);
      check("out_valid_after", out_valid, 0);
      @(posedge clk);
      #1;
      check("done_clear", done, 0);
      check("busy_idle", busy, 0);
   endtask

   initial begin
      vec_t v;
      tbl[0] = '{a: {8'd4, 8'd3, 8'd2, 8'd1}, b: {8'd8, 8'd7, 8'd6, 8'd5},
                 c: {17'd50, 17'd43, 17'd22, 17'd19}, stall: 0, hold: 1'b0};
`ifdef MATMUL_SIGNED_EN
      tbl[1] = '{a: {4{8'hFF}}, b: {8'd4, 8'd3, 8'd2, 8'd1},
                 c: {17'h1FFFA, 17'h1FFFC, 17'h1FFFA, 17'h1FFFC}, stall: 0, hold: 1'b0};
`else
      tbl[1] = '{a: {4{8'hFF}}, b: {4{8'hFF}}, c: {4{17'd130050}}, stall: 0, hold: 1'b0};
`endif
      tbl[2] = tbl[0];
      tbl[2].stall = 5;
      tbl[3] = tbl[0];
      tbl[3].hold = 1'b1;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_a = '0;
      in_b = '0;
      #2;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int t = 0; t < 4; t++) run(tbl[t]);
      for (int t = 0; t < 6; t++) begin
         v.a = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
         v.b = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
         v.c = model(v.a, v.b);
         v.stall = int'($urandom_range(0, 2));
         v.hold = 1'($urandom);
         run(v);
      end
      load(tbl[0].a, tbl[0].b);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_data", out_data, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      v = '{a: {8'd1, 8'd0, 8'd0, 8'd1}, b: {8'd6, 8'd7, 8'd8, 8'd9},
            c: {17'd6, 17'd7, 17'd8, 17'd9}, stall: 1, hold: 1'b0};
      run(v);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Controller that sequences a shared single-MAC datapath to compute C = A×B for N×N matrices. Streams A/B element pairs in over a valid/ready port, runs N³ multiply-accumulate steps on one multiplier, and streams C elements out over a second valid/ready port. Sits between the tile's byte-wide input pins (A, B) and output pins (C) as the block that owns the multiply datapath.

## Interface
- N, 2: matrix dimension (N ≥ 2)
- DW, 8: element width of A and B
- ACC_W, 2*DW+$clog2(N): C element width (derived, not overridden)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  A/B element pair valid
- in_ready  out  1  sequencer accepts a pair this cycle
- in_a  in  DW  A element, row-major order
- in_b  in  DW  B element, row-major order
- out_valid  out  1  C element valid
- out_ready  in  1  consumer accepts C element
- out_data  out  ACC_W  C element, row-major order
- busy  out  1  high in COMPUTE or DRAIN
- done  out  1  one-cycle pulse when final C element is accepted

## Operation
- States: LOAD, COMPUTE, DRAIN. Reset state LOAD.
- LOAD: in_ready=1. Each in_valid&&in_ready beat writes A[r][c] and B[r][c] at load index (0..N²-1, row-major). Beat at index N²-1 → COMPUTE next cycle.
- COMPUTE: in_ready=0; in_valid ignored. Counters i,j,k nest k innermost, each 0..N-1. Each cycle: sum = (k==0 ? 0 : acc) + A[i][k]*B[k][j]; acc <= sum; when k==N-1, C[i][j] <= sum. After (i,j,k)=(N-1,N-1,N-1) → DRAIN.
- DRAIN: out_valid=1, out_data=C[drain index]. Index advances only on out_valid&&out_ready. Final beat accepted → done=1 that cycle's next edge for one cycle, state → LOAD, all counters to 0.
- Arithmetic: unsigned by default; product 2*DW bits, zero-extended to ACC_W. No overflow possible at ACC_W.
- Reset (any time, incl. mid-COMPUTE/DRAIN): state LOAD, all counters 0, acc 0, A/B/C buffers 0; partial results discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0, done=0.
- Load: one pair per cycle max; N² accepted beats.
- COMPUTE lasts exactly N³ cycles. Last load beat accepted at edge t → out_valid first high after edge t+1+N³ (N=2: 9 edges).
- out_data stable and out_valid held while out_valid&&!out_ready.
- Unstalled drain: N² cycles. done high the cycle after final accept; in_ready high same cycle.
- in_valid&&in_ready and done never coincide with out_valid.

## Configuration
- MATMUL_SIGNED_EN defined: A, B two's-complement; products signed, sign-extended to ACC_W; C two's-complement.
- Undefined: unsigned arithmetic as above.

## Structure
- Package matmul_pkg: state enum (LOAD, COMPUTE, DRAIN), ACC_W derivation function, index-width constants.
- Sub-module matmul_mac: combinational multiply + add of (clear ? 0 : acc_in) with product; honours MATMUL_SIGNED_EN. FSM, counters, buffers stay in matmul_sequencer.

## Test plan
- N=2 unsigned: A=[1,2,3,4], B=[5,6,7,8], out_ready=1 → C=19,22,43,50 in order; out_valid first high 9 cycles after last load; done pulse once.
- Max values: A=B=all 255 → every C=130050, no wrap.
- Backpressure: out_ready low 5 cycles at each element → out_data held, no element lost or repeated.
- in_valid held high during COMPUTE/DRAIN → in_ready=0, buffers unchanged, results match.
- rst asserted mid-COMPUTE → outputs at reset values immediately; new load A=identity, B=[9,8,7,6] → C=9,8,7,6.
- MATMUL_SIGNED_EN: A=all -1, B=[1,2,3,4] → C=-4,-6,-4,-6.
